// File: rtl/boot_byte_loader.sv
// Byte-stream front end for program loading: parses MAGIC/base/count/payload/checksum
// frames and emits one load strobe per assembled little-endian 32-bit word.
module boot_byte_loader #(
  parameter logic [7:0] MAGIC = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [7:0]  i_in_data,
  input  logic        i_ack,
  output logic        o_load_en,
  output logic [31:0] o_load_addr,
  output logic [31:0] o_load_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_word_cnt
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StCount, StData, StCsum, StDone, StErr
  } state_e;

  state_e      r_state;
  logic [1:0]  r_idx;
  logic [23:0] r_lo;        // low bytes of base address or current word, filled from the top
  logic [7:0]  r_n_lo;
  logic [15:0] r_n;
  logic [31:0] r_addr;
  logic [7:0]  r_csum;
  logic [15:0] r_word_cnt;
  logic        r_load_en;
  logic [31:0] r_load_addr;
  logic [31:0] r_load_data;

  logic        w_fire;
  logic [31:0] w_full;
  logic [15:0] w_next_cnt;

  assign o_in_ready = !i_rst && (r_state != StDone) && (r_state != StErr);
  assign w_fire     = i_in_valid && o_in_ready;
  assign w_full     = {i_in_data, r_lo};
  assign w_next_cnt = r_word_cnt + 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_idx       <= 2'd0;
      r_lo        <= 24'd0;
      r_n_lo      <= 8'd0;
      r_n         <= 16'd0;
      r_addr      <= 32'd0;
      r_csum      <= 8'd0;
      r_word_cnt  <= 16'd0;
      r_load_en   <= 1'b0;
      r_load_addr <= 32'd0;
      r_load_data <= 32'd0;
    end else begin
      r_load_en <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_fire && i_in_data == MAGIC) begin
            r_state    <= StAddr;
            r_idx      <= 2'd0;
            r_word_cnt <= 16'd0;
            r_csum     <= 8'd0;
          end
        end
        StAddr: begin
          if (w_fire) begin
            r_lo  <= {i_in_data, r_lo[23:8]};
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_addr  <= w_full;
              r_state <= (r_lo[1:0] != 2'd0) ? StErr : StCount;
            end
          end
        end
        StCount: begin
          if (w_fire) begin
            r_n_lo <= i_in_data;
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd1) begin
              r_n     <= {i_in_data, r_n_lo};
              r_idx   <= 2'd0;
              r_state <= ({i_in_data, r_n_lo} == 16'd0) ? StCsum : StData;
            end
          end
        end
        StData: begin
          if (w_fire) begin
            r_lo   <= {i_in_data, r_lo[23:8]};
            r_csum <= r_csum + i_in_data;
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_load_en   <= 1'b1;
              r_load_data <= w_full;
              r_load_addr <= r_addr;
              r_addr      <= r_addr + 32'd4;
              r_word_cnt  <= w_next_cnt;
              if (w_next_cnt == r_n) r_state <= StCsum;
            end
          end
        end
        StCsum: begin
          if (w_fire) r_state <= (i_in_data == r_csum) ? StDone : StErr;
        end
        StDone, StErr: begin
          if (i_ack) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_load_en   = r_load_en;
  assign o_load_addr = r_load_addr;
  assign o_load_data = r_load_data;
  assign o_word_cnt  = r_word_cnt;
  assign o_busy      = (r_state == StAddr) || (r_state == StCount) ||
                       (r_state == StData) || (r_state == StCsum);
  assign o_done      = (r_state == StDone);
  assign o_error     = (r_state == StErr);

endmodule

// File: doc/boot_byte_loader.md
# boot_byte_loader

Byte-stream front end for program loading. It sits directly upstream of the ROM-write loader and drives its `load_en` / `load_addr` / `load_data` inputs. It accepts a framed byte stream over a valid/ready handshake, checks the header, and assembles little-endian 32-bit words. For each completed word it emits a one-cycle load strobe with an incrementing address, then verifies a payload checksum at frame end.

## Interface
- `MAGIC`, default 8'hA5: frame start byte.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_ready` out 1: block accepts a byte this cycle; a byte transfers when `in_valid & in_ready` at a rising edge.
- `in_data` in 8: stream byte.
- `ack` in 1: clears DONE/ERR and returns to IDLE.
- `load_en` out 1: one-cycle strobe, word ready for the loader.
- `load_addr` out 32: word address.
- `load_data` out 32: assembled word.
- `busy` out 1: frame in progress.
- `done` out 1: frame accepted, checksum matched (level).
- `error` out 1: frame rejected (level).
- `word_cnt` out 16: words emitted in the current or last frame.

## Operation
- Frame format: MAGIC, base address (4 bytes, LE), word count N (2 bytes, LE), N×4 payload bytes (LE per word), checksum (1 byte).
- Checksum: 8-bit sum, mod 256, of all payload bytes; N=0 gives expected checksum 8'h00.
- **IDLE**
  - Accepts bytes.
  - Non-MAGIC bytes are discarded; state stays IDLE.
  - MAGIC → ADDR; clears `word_cnt`, checksum accumulator and byte index.
- **ADDR**: collects 4 bytes.
  - After the 4th byte: if base[1:0] != 0 → ERR; else → COUNT.
- **COUNT**: collects 2 bytes.
  - After the 2nd byte: N==0 → CSUM; else → DATA.
- **DATA**
  - Shifts bytes into a word register; byte 0 lands in bits [7:0].
  - Adds each byte to the checksum accumulator.
  - On the 4th byte of word k:
    - `load_data` = assembled word.
    - `load_addr` = base + 4k, wrapping mod 2^32.
    - `load_en` asserted.
    - `word_cnt` incremented.
  - After word N-1 → CSUM.
- **CSUM**: one byte; equal to accumulator → DONE, else → ERR.
- **DONE** / **ERR**
  - `in_ready`=0; `done` or `error` held high respectively.
  - `ack` → IDLE next cycle.
  - `ack` in any other state is ignored.
- `busy` = 1 in ADDR, COUNT, DATA, CSUM.
- `in_ready` = 1 in IDLE, ADDR, COUNT, DATA, CSUM, and 0 while `rst` is high.
- `load_addr` / `load_data` hold their last values between strobes.

## Timing
- **Reset values**: `load_en`=0, `load_addr`=0, `load_data`=0, `busy`=0, `done`=0, `error`=0, `word_cnt`=0, state IDLE.
- **Throughput**: one byte per cycle sustained, with no bubbles between words.
- **Strobe latency**: `load_en` is registered and goes high the cycle after the edge that accepts a word's 4th byte. It lasts exactly 1 cycle; back-to-back words give a strobe every 4 cycles at full rate.
- **Visibility**: `done`/`error` are visible the cycle after the checksum byte is accepted.
- **Stalls**: `in_valid`=0 stalls any state with no side effects; a partial word is retained.
- **`ack` with `in_valid` in DONE/ERR**: no byte is accepted (`in_ready`=0). IDLE is reached the next cycle, and the byte is taken then if still valid.
- **Reset mid-frame**: `rst` high at an edge forces IDLE and drops the partial word. `load_en`=0 from that edge; no strobe is emitted for the discarded word.
- **Last word**: the final word's `load_en` precedes the CSUM transition. A bad checksum does not retract words already strobed.

## Test plan
- **Nominal frame**
  - Stimulus: A5, 00 00 00 80, 02 00, 13 00 00 00, 93 00 10 00, B6.
  - Required: two strobes, (0x80000000, 0x00000013) then (0x80000004, 0x00100093); `done`=1, `word_cnt`=2, `error`=0.
- **Bad checksum**
  - Stimulus: same frame with final byte B7.
  - Required: both strobes still occur; `error`=1, `done`=0; after `ack`, IDLE with `in_ready`=1.
- **Misaligned base / zero length**
  - Stimulus: A5, 02 00 00 80 → ERR with no strobes.
  - Stimulus: A5, 00 00 00 80, 00 00, 00 → DONE with `word_cnt`=0.
- **Garbage and wrap**
  - Stimulus: FF 00 then A5, FC FF FF FF, 02 00, two words, correct checksum.
  - Required: leading bytes ignored; addresses 0xFFFFFFFC then 0x00000000.
- **Random `in_valid` gaps**
  - Stimulus: nominal frame with `in_valid` gaps inserted at random.
  - Required: identical strobe contents; each `load_en` exactly 1 cycle wide.
- **Reset mid-frame**
  - Stimulus: `rst` asserted after 2 payload bytes of word 0.
  - Required: no strobe; all outputs return to reset values; a following nominal frame loads correctly.
